seq_det_prog: RTL and testbench

Programmable serial pattern detector: generalises the fixed "110" one-hot detector to a runtime-loadable pattern of 1..MAX_LEN bits, with overlap/non-overlap mode, enable gating and a saturating match counter. Sits on the same single-bit serial stream as the existing detector. After reset it detects "110" non-overlapping, so it is a drop-in upgrade.

---
 rtl/seq_det_prog.sv | 98 +++++++++
 tb/tb_seq_det_prog.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: runtime-loadable 1..MAX_LEN bit pattern,
// overlap/non-overlap mode, enable gating and a saturating match counter.
module seq_det_prog #(
   parameter int                 MAX_LEN = 8,
   parameter int                 CNT_W   = 8,
   parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_0110,
   parameter int                 DEF_LEN = 3,
   parameter bit                 DEF_OVL = 1'b0,
   localparam int                LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               seq_in,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_ovl,
   input  logic               clr_cnt,
   output logic               det_out,
   output logic [CNT_W-1:0]   match_cnt,
   output logic [LEN_W-1:0]   fill
);

   logic [MAX_LEN-1:0] pat_r;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;
   logic [MAX_LEN:0]   window;
   logic [MAX_LEN:0]   mask;
   logic [LEN_W:0]     fill_inc;
   logic [LEN_W-1:0]   fill_next;
   logic [LEN_W-1:0]   len_clamp;
   logic               sample;
   logic               match;

   assign window = {hist, seq_in};
   assign sample = en & ~cfg_load;

   // Only the newest len_r bits take part; the top window bit is never compared.
   always_comb begin
      mask = '0;
      for (int i = 0; i <= MAX_LEN; i++) begin
         mask[i] = (i < int'(len_r));
      end
   end

   assign fill_inc  = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
   assign len_clamp = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

   assign match = sample && (len_r != '0) && (fill_inc >= {1'b0, len_r}) &&
                  (((window ^ {1'b0, pat_r}) & mask) == '0);

   always_comb begin
      fill_next = fill;
      if (match && !ovl_r) begin
         fill_next = '0;
      end else if (fill != LEN_W'(MAX_LEN)) begin
         fill_next = fill_inc[LEN_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_r   <= DEF_PAT;
         len_r   <= LEN_W'(DEF_LEN);
         ovl_r   <= DEF_OVL;
         hist    <= '0;
         fill    <= '0;
         det_out <= 1'b0;
      end else if (cfg_load) begin
         pat_r   <= cfg_pat;
         len_r   <= len_clamp;
         ovl_r   <= cfg_ovl;
         hist    <= '0;
         fill    <= '0;
         det_out <= 1'b0;
      end else if (en) begin
         hist    <= window[MAX_LEN-1:0];
         fill    <= fill_next;
         det_out <= match;
      end else begin
         det_out <= 1'b0;
      end
   end

   // Counter clear wins over a coincident match; the count never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_cnt <= '0;
      end else if (clr_cnt) begin
         match_cnt <= '0;
      end else if (match && (match_cnt != '1)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_det_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             en       = 1'b0;
   logic             seq_in   = 1'b0;
   logic             cfg_load = 1'b0;
   logic [7:0]       cfg_pat  = 8'h00;
   logic [LEN_W-1:0] cfg_len  = '0;
   logic             cfg_ovl  = 1'b0;
   logic             clr_cnt  = 1'b0;
   logic             det_out, det2;
   logic [7:0]       match_cnt;
   logic [1:0]       cnt2;
   logic [LEN_W-1:0] fill, fill2;

   seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .seq_in(seq_in), .cfg_load(cfg_load),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .clr_cnt(clr_cnt),
      .det_out(det_out), .match_cnt(match_cnt), .fill(fill));

   seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .seq_in(seq_in), .cfg_load(cfg_load),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .clr_cnt(clr_cnt),
      .det_out(det2), .match_cnt(cnt2), .fill(fill2));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference model: the bits usable for the next match live in a queue.
   bit         q[$];
   logic [7:0] m_pat  = 8'h06;
   int         m_len  = 3;
   bit         m_ovl  = 1'b0;
   bit         m_det  = 1'b0;
   int         m_cnt  = 0;
   int         m_cnt2 = 0;

   always @(posedge clk or negedge rst) begin
      bit hit;
      if (!rst) begin
         m_pat = 8'h06; m_len = 3; m_ovl = 1'b0; m_det = 1'b0;
         m_cnt = 0; m_cnt2 = 0;
         q.delete();
      end else begin
         hit = 1'b0;
         if (cfg_load) begin
            m_pat = cfg_pat;
            m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_ovl;
            q.delete();
         end else if (en) begin
            q.push_back(seq_in);
            if (m_len != 0 && q.size() >= m_len) begin
               hit = 1'b1;
               for (int k = 0; k < m_len; k++)
                  if (q[q.size()-1-k] != m_pat[k]) hit = 1'b0;
            end
            if (hit && !m_ovl) q.delete();
            else if (q.size() > MAX_LEN) void'(q.pop_front());
         end
         m_det = hit;
         if (clr_cnt) begin
            m_cnt = 0; m_cnt2 = 0;
         end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
   end

   always @(negedge clk) begin
      chk("det_out", det_out, m_det);
      chk("match_cnt", match_cnt, m_cnt);
      chk("fill", fill, q.size());
      chk("det_out_w2", det2, m_det);
      chk("match_cnt_w2", cnt2, m_cnt2);
   end

   logic [15:0] dv = '0;

   task automatic send(input logic b, input logic c = 1'b0);
      @(negedge clk);
      en = 1'b1; seq_in = b; cfg_load = 1'b0; clr_cnt = c;
      @(posedge clk);
      #1 dv = {dv[14:0], det_out};
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send(bits[i]);
   endtask

   task automatic idle();
      @(negedge clk);
      en = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
      @(posedge clk);
      #1 dv = {dv[14:0], det_out};
   endtask

   task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o);
      @(negedge clk);
      cfg_load = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; clr_cnt = 1'b0;
      en = 1'($urandom); seq_in = 1'($urandom);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int r;
      #1 rst = 1'b0;
      #3;
      chk("reset_det", det_out, 0);
      chk("reset_cnt", match_cnt, 0);
      chk("reset_fill", fill, 0);
      @(negedge clk) rst = 1'b1;

      // Default "110" non-overlapping after reset
      dv = '0; send_bits(16'b110110, 6);
      chk("t1_pulses", dv[5:0], 6'b001001);
      chk("t1_cnt", match_cnt, 2);

      dv = '0; send_bits(16'b11110, 5);
      chk("t2_pulses", dv[4:0], 5'b00001);
      chk("t2_fill", fill, 0);
      chk("t2_cnt", match_cnt, 3);

      load(8'h05, 4'd3, 1'b1);
      dv = '0; send_bits(16'b10101, 5);
      chk("t3_ovl_pulses", dv[4:0], 5'b00101);
      chk("t3_ovl_cnt", match_cnt, 5);
      load(8'h05, 4'd3, 1'b0);
      dv = '0; send_bits(16'b10101, 5);
      chk("t3_novl_pulses", dv[4:0], 5'b00100);
      chk("t3_novl_cnt", match_cnt, 6);

      load(8'h06, 4'd3, 1'b0);
      dv = '0; send(1'b1);
      repeat (4) begin
         idle();
         chk("t4_fill_hold", fill, 1);
      end
      send(1'b1); send(1'b0);
      chk("t4_pulses", dv[6:0], 7'b0000001);
      chk("t4_cnt", match_cnt, 7);

      chk("t5_sat", cnt2, 3);
      load(8'h01, 4'd1, 1'b1);
      send(1'b1, 1'b1);
      chk("t5_clr_det", det_out, 1);
      chk("t5_clr_cnt", match_cnt, 0);
      chk("t5_clr_cnt_w2", cnt2, 0);
      send(1'b1);
      chk("t5_after_clr", match_cnt, 1);

      load(8'h00, 4'd0, 1'b0);
      dv = '0;
      repeat (16) send(1'($urandom));
      send_bits(16'h0000, 8);
      chk("t6_len0_pulses", dv, 0);
      chk("t6_len0_cnt", match_cnt, 1);

      load(8'hA5, 4'd15, 1'b0);
      dv = '0; send_bits(16'h52, 7);
      chk("t6_a5_fill7", fill, 7);
      send(1'b1);
      chk("t6_a5_pulses", dv[7:0], 8'b00000001);
      chk("t6_a5_cnt", match_cnt, 2);

      load(8'hA5, 4'd15, 1'b1);
      send_bits(16'hA5, 8);
      chk("t7_pre_det", det_out, 1);
      chk("t7_pre_fill", fill, 8);
      rst = 1'b0;
      #1;
      chk("t7_rst_det", det_out, 0);
      chk("t7_rst_fill", fill, 0);
      chk("t7_rst_cnt", match_cnt, 0);
      @(negedge clk) rst = 1'b1;
      dv = '0; send_bits(16'b110, 3);
      chk("t7_default_back", dv[2:0], 3'b001);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         r = $urandom_range(0, 999);
         rst      = 1'b1;
         cfg_load = (r >= 2 && r < 25);
         en       = ($urandom_range(0, 9) < 8);
         seq_in   = 1'($urandom);
         clr_cnt  = ($urandom_range(0, 99) == 0);
         if (cfg_load) begin
            cfg_pat = 8'($urandom);
            cfg_len = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4))
                                                  : 4'($urandom_range(0, 15));
            cfg_ovl = 1'($urandom);
         end
         if (r < 2) #2 rst = 1'b0;
      end
      @(negedge clk) rst = 1'b1;
      idle(); idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
